// File: rtl/return_reducer.sv
// Gathers one word per child channel in any order, then reduces the round
// (sum modulo 2^WIDTH or XOR fold) into a registered result with valid/ready.
module return_reducer #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned MODE     = 0
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          return_data,
    output logic                      return_carry,
    output logic                      return_parity,
    output logic                      return_valid,
    input  logic                      return_ready
);

    localparam int unsigned SUM_W = WIDTH + $clog2(CHANNELS) + 1;

    typedef enum logic [1:0] {COLLECT, COMBINE, OUTPUT} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CHANNELS-1:0]       captured;
    logic [CHANNELS*WIDTH-1:0] held;
    logic [CHANNELS-1:0]       take;
    logic [SUM_W-1:0]          sum_c;
    logic [WIDTH-1:0]          fold_c;
    logic [WIDTH-1:0]          result_c;
    logic                      carry_c;

    // Only uncaptured channels are offered ready, and never while in reset.
    always_comb begin
        in_ready = '0;
        if (state == COLLECT && !_reset) begin
            in_ready = ~captured;
        end
        take = in_valid & in_ready;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (&captured)   state_next = COMBINE;
            COMBINE:                  state_next = OUTPUT;
            OUTPUT:  if (return_ready) state_next = COLLECT;
            default:                  state_next = COLLECT;
        endcase
    end

    // Sum is wide enough that no overflow is lost before the carry fold.
    always_comb begin
        sum_c  = '0;
        fold_c = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            sum_c  = sum_c + SUM_W'(held[k*WIDTH +: WIDTH]);
            fold_c = fold_c ^ held[k*WIDTH +: WIDTH];
        end
        result_c = (MODE == 0) ? sum_c[WIDTH-1:0] : fold_c;
        carry_c  = (MODE == 0) ? |sum_c[SUM_W-1:WIDTH] : 1'b0;
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state         <= COLLECT;
            captured      <= '0;
            return_data   <= '0;
            return_carry  <= 1'b0;
            return_parity <= 1'b0;
            return_valid  <= 1'b0;
        end else begin
            state        <= state_next;
            return_valid <= (state_next == OUTPUT);
            case (state)
                COLLECT: begin
                    for (int k = 0; k < int'(CHANNELS); k++) begin
                        if (take[k]) begin
                            held[k*WIDTH +: WIDTH] <= in_data[k*WIDTH +: WIDTH];
                        end
                    end
                    captured <= captured | take;
                end
                COMBINE: begin
                    return_data   <= result_c;
                    return_carry  <= carry_c;
                    return_parity <= ^result_c;
                end
                OUTPUT: begin
                    if (return_ready) begin
                        captured <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
